// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the block-RAM window reader and its output FIFO.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH   = 4;
  localparam int FIFO_PTR_W   = 2;
  localparam int FIFO_CNT_W   = 3;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/bram_rd_fifo.sv
// Four-entry synchronous FIFO buffering RAM read data ahead of the stream port.
module bram_rd_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [W-1:0]          data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;

  // Storage is cleared on reset so the head word reads as zero while empty.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Drains an address window from a 1-cycle-latency RAM read port into a
// valid/ready stream with tlast, throttled so the 4-deep FIFO never overflows.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rd_reset,
  input  logic                       start,
  input  logic [C_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [C_ADDRESS_WIDTH:0]   length,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_re,
  output logic [C_ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [C_DATA_WIDTH-1:0]    ram_q,
  output logic                       m_tvalid,
  output logic [C_DATA_WIDTH-1:0]    m_tdata,
  output logic                       m_tlast,
  input  logic                       m_tready
);

  localparam logic [C_ADDRESS_WIDTH:0] CNT_ONE    = (C_ADDRESS_WIDTH+1)'(1);
  localparam logic [FIFO_CNT_W:0]      CREDIT_MAX = (FIFO_CNT_W+1)'(FIFO_DEPTH);

  state_e                     state_q, state_d;
  logic [C_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [C_ADDRESS_WIDTH:0]   issue_q, issue_d;
  logic [C_ADDRESS_WIDTH:0]   beats_q, beats_d;
  logic                       done_q, done_d;
  logic                       rd_v1_q;

  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [FIFO_CNT_W-1:0]      fifo_cnt_s;
  logic [FIFO_CNT_W:0]        credit_s;
  logic                       ram_re_s;
  logic                       hs_s;
  logic                       last_beat_s;

  // Words already buffered plus the one read whose data arrives this cycle.
  assign credit_s    = {1'b0, fifo_cnt_s} + {{FIFO_CNT_W{1'b0}}, rd_v1_q};
  assign ram_re_s    = (state_q == ST_RUN) && (issue_q != '0) && !fifo_full_s
                       && (credit_s < CREDIT_MAX);
  assign hs_s        = !fifo_empty_s && m_tready;
  assign last_beat_s = (beats_q == CNT_ONE);

  // State, counters, done pulse and the read-valid pipe.
  always_ff @(posedge clk) begin
    if (rd_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      issue_q <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
      rd_v1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      rd_v1_q <= ram_re_s;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    if (ram_re_s) begin
      addr_d  = addr_q + 1'b1;
      issue_d = issue_q - CNT_ONE;
    end else begin
      issue_d = issue_q;
    end
    if (hs_s) begin
      beats_d = beats_q - CNT_ONE;
    end else begin
      beats_d = beats_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start && (length != '0)) begin
          state_d = ST_RUN;
          addr_d  = base_addr;
          issue_d = length;
          beats_d = length;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ram_re_s && (issue_q == CNT_ONE)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (hs_s && last_beat_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  bram_rd_fifo #(
    .W(C_DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_i  (rd_reset),
    .push_i (rd_v1_q),
    .data_i (ram_q),
    .pop_i  (hs_s),
    .data_o (m_tdata),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .count_o(fifo_cnt_s)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign ram_re   = ram_re_s;
  assign ram_addr = addr_q;
  assign m_tvalid = !fifo_empty_s;
  assign m_tlast  = !fifo_empty_s && last_beat_s;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: table of windows plus cycle-exact corner sequences.
module tb_bram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rd_reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_re, m_tvalid, m_tlast, m_tready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = 8'h00;
  logic [DW-1:0] m_tdata;
  logic [DW-1:0] ram [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;      // 0: always ready, 1: random ready
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  bram_stream_reader #(.C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rd_reset(rd_reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_q(ram_q), .m_tvalid(m_tvalid),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  // RAM model: registered read, gated by read enable.
  always @(posedge clk) begin
    if (ram_re) ram_q <= ram[ram_addr];
  end

  function automatic logic [7:0] exp_data(input logic [7:0] a);
    return (a ^ 8'h5C) + 8'd17;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base_addr = b; length = l;
    step();
    start = 1'b0;
  endtask

  // Collects a whole window and checks order, tlast and the done pulse.
  task automatic collect(input logic [AW-1:0] b, input int len, input int mode,
                         input logic [AW-1:0] exp_last);
    int beat = 0;
    int cyc = 0;
    int tl = 0;
    logic [AW-1:0] a;
    logic [AW-1:0] last_a = '0;
    while (beat < len && cyc < 4000) begin
      m_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_tvalid && m_tready) begin
        a = b + 8'(beat);
        if (m_tdata !== exp_data(a)) chk("beat_data", {24'h0, m_tdata}, {24'h0, exp_data(a)});
        if (m_tlast !== (beat == len - 1)) chk("beat_tlast", {31'h0, m_tlast}, {31'h0, beat == len - 1});
        if (m_tlast) begin tl++; last_a = a; end
        beat++;
      end
      step();
      cyc++;
    end
    m_tready = 1'b0;
    chk("beat_count", beat, len);
    chk("tlast_count", tl, 1);
    chk("tlast_addr", {24'h0, last_a}, {24'h0, exp_last});
    chk("done_after_last", {31'h0, done}, 32'd1);
    chk("busy_after_last", {31'h0, busy}, 32'd0);
    step();
    chk("done_one_cycle", {31'h0, done}, 32'd0);
    chk("no_extra_beat", {31'h0, m_tvalid}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    int re_cnt;
    for (int i = 0; i < 256; i++) ram[i] = exp_data(8'(i));
    vecs[0] = '{base: 8'd3,   len: 9'd5,   mode: 0, exp_last_addr: 8'd7};
    vecs[1] = '{base: 8'd254, len: 9'd4,   mode: 0, exp_last_addr: 8'd1};
    vecs[2] = '{base: 8'd128, len: 9'd256, mode: 1, exp_last_addr: 8'd127};
    vecs[3] = '{base: 8'd250, len: 9'd1,   mode: 1, exp_last_addr: 8'd250};
    vecs[4] = '{base: 8'd0,   len: 9'd256, mode: 0, exp_last_addr: 8'd255};

    rd_reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_tready = 1'b0;
    step(); step();
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_ram_re", {31'h0, ram_re}, 32'd0);
    chk("rst_ram_addr", {24'h0, ram_addr}, 32'd0);
    chk("rst_tvalid", {31'h0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'h0, m_tlast}, 32'd0);
    chk("rst_tdata", {24'h0, m_tdata}, 32'd0);
    rd_reset = 1'b0;
    step();

    // Cycle-exact latency: base 3, length 5, always ready.
    m_tready = 1'b1;
    pulse_start(8'd3, 9'd5);
    for (int c = 1; c <= 8; c++) begin
      chk("lat_ram_re", {31'h0, ram_re}, {31'h0, (c >= 1 && c <= 5)});
      if (c <= 5) chk("lat_ram_addr", {24'h0, ram_addr}, 32'(c + 2));
      chk("lat_tvalid", {31'h0, m_tvalid}, {31'h0, (c >= 3 && c <= 7)});
      if (c >= 3 && c <= 7) chk("lat_tdata", {24'h0, m_tdata}, {24'h0, exp_data(8'(c))});
      chk("lat_tlast", {31'h0, m_tlast}, {31'h0, c == 7});
      chk("lat_done", {31'h0, done}, {31'h0, c == 8});
      chk("lat_busy", {31'h0, busy}, {31'h0, c <= 7});
      step();
    end
    m_tready = 1'b0;

    for (int v = 0; v < 5; v++) begin
      pulse_start(vecs[v].base, vecs[v].len);
      collect(vecs[v].base, int'(vecs[v].len), vecs[v].mode, vecs[v].exp_last_addr);
    end

    // Backpressure: ready low for cycles 0..15.
    m_tready = 1'b0;
    re_cnt = 0;
    pulse_start(8'd0, 9'd10);
    held = '0;
    for (int c = 1; c <= 15; c++) begin
      if (ram_re) re_cnt++;
      if (c == 3) held = m_tdata;
      if (c >= 3) begin
        if (m_tvalid !== 1'b1) chk("stall_tvalid", {31'h0, m_tvalid}, 32'd1);
        if (m_tdata !== held) chk("stall_stable", {24'h0, m_tdata}, {24'h0, held});
      end
      step();
    end
    chk("stall_re_pulses", re_cnt, 4);
    chk("stall_head", {24'h0, held}, {24'h0, exp_data(8'd0)});
    collect(8'd0, 10, 0, 8'd9);

    // Zero-length request.
    start = 1'b1; base_addr = 8'd9; length = 9'd0;
    step();
    start = 1'b0;
    chk("len0_done", {31'h0, done}, 32'd1);
    chk("len0_busy", {31'h0, busy}, 32'd0);
    chk("len0_ram_re", {31'h0, ram_re}, 32'd0);
    chk("len0_tvalid", {31'h0, m_tvalid}, 32'd0);
    step();
    chk("len0_done_clear", {31'h0, done}, 32'd0);
    chk("len0_busy_late", {31'h0, busy}, 32'd0);

    // Start while busy is ignored.
    pulse_start(8'd20, 9'd6);
    pulse_start(8'd100, 9'd3);
    collect(8'd20, 6, 0, 8'd25);

    // Reset during beat 3 of an 8-word window.
    m_tready = 1'b1;
    pulse_start(8'd40, 9'd8);
    step(); step(); step(); step();
    rd_reset = 1'b1;
    step();
    rd_reset = 1'b0;
    chk("abort_tvalid", {31'h0, m_tvalid}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_ram_re", {31'h0, ram_re}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    step();
    chk("abort_done_late", {31'h0, done}, 32'd0);
    chk("abort_tvalid_late", {31'h0, m_tvalid}, 32'd0);
    m_tready = 1'b0;
    pulse_start(8'd60, 9'd8);
    collect(8'd60, 8, 0, 8'd67);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side counterpart of the streaming RAM loader: the loader fills a dual-port block RAM sequentially; this block drains a programmed address window from one RAM read port.
- Emits the window as a valid/ready stream with tlast on the final word.
- Sits between a RAM read port (1-cycle registered read latency, read-enable gated) and a downstream stream consumer. Absorbs consumer backpressure without losing or duplicating words.

Parameters:
- C_DATA_WIDTH, 8, RAM word and stream data width
- C_ADDRESS_WIDTH, 8, RAM address width; RAM depth is 2**C_ADDRESS_WIDTH

Ports:
- clk  in  1  single clock for all logic
- rd_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to read a window; sampled only when busy=0
- base_addr  in  C_ADDRESS_WIDTH  first RAM address of window, sampled with start
- length  in  C_ADDRESS_WIDTH+1  word count, 0..2**C_ADDRESS_WIDTH, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the window is complete
- ram_re  out  1  RAM read enable
- ram_addr  out  C_ADDRESS_WIDTH  RAM read address
- ram_q  in  C_DATA_WIDTH  RAM read data, valid the cycle after ram_re
- m_tvalid  out  1  stream word valid
- m_tdata  out  C_DATA_WIDTH  stream word
- m_tlast  out  1  marks final word of window
- m_tready  in  1  consumer accept

Behaviour:
- Reset (rd_reset=1 at a clk edge) takes effect regardless of state. It clears busy, done, ram_re, ram_addr, m_tvalid, m_tlast and m_tdata to 0, and returns the FSM to IDLE. It empties the FIFO, discards in-flight reads and clears all counters. Reset mid-window aborts the window with no done pulse.
- FSM states:
  - IDLE: start=1 with length>0 loads the address pointer, issue count and beat count, sets busy, and goes to RUN. start=1 with length=0 pulses done in the next cycle; busy stays 0 and no beats are sent.
  - RUN: issues reads. Goes to DRAIN when the last read has been issued.
  - DRAIN: waits for the final beat handshake, then goes to IDLE. In the cycle after that handshake, done=1 and busy=0.
- start while busy=1 is ignored; parameters of the active window are unaffected.
- Read issue:
  - In RUN, ram_re=1 iff reads remaining>0 and (words in FIFO + reads in flight) < 4.
  - ram_addr increments after each issued read and wraps modulo 2**C_ADDRESS_WIDTH.
  - Each issued read is tracked through a 2-stage valid pipe. Stage 1 is the cycle ram_re=1. Stage 2 is the cycle ram_q is valid; at the end of stage 2, ram_q is pushed into the FIFO.
- Output FIFO:
  - 4 entries, registered outputs; m_tvalid is asserted when the FIFO is non-empty.
  - Push and pop in the same cycle are legal at any occupancy reachable under the credit rule. The credit rule guarantees the FIFO never overflows.
- Latency: start in cycle 0 → ram_re=1 in cycle 1 → m_tvalid=1 in cycle 3.
- Throughput: with m_tready held at 1, one word per cycle, no bubbles.
- Handshake:
  - A word transfers when m_tvalid & m_tready.
  - m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never drops without a transfer.
- m_tlast=1 only on the beat whose beat count equals length.
- length = 2**C_ADDRESS_WIDTH reads the entire RAM once, starting at base_addr and wrapping.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN, DRAIN)
  - constant FIFO_DEPTH=4 and its count width
  - constant READ_LATENCY=1
- Sub-module bram_rd_fifo: 4-deep synchronous FIFO with push, pop, full, empty and count. The top level keeps the FSM, the credit/in-flight tracking and the counters.

Test Plan:
- base=3, length=5, m_tready=1 → ram_re high in cycles 1..5 with ram_addr 3..7. Data words for addresses 3..7 appear on m_tdata in cycles 3..7, m_tlast in cycle 7, done in cycle 8, busy low in cycle 8.
- C_ADDRESS_WIDTH=8, base=254, length=4 → ram_addr sequence 254, 255, 0, 1; 4 beats in order; tlast on the word from address 1.
- base=0, length=10, m_tready=0 for cycles 0..15, then 1 → exactly 4 ram_re pulses before stall; m_tdata stable while stalled. After release, all 10 words delivered in order, none lost or duplicated.
- length=0 start → done=1 in cycle 1, busy stays 0, no ram_re, no m_tvalid. start pulsed again while busy during a length=6 window → ignored, exactly 6 beats.
- length=256 (width 8), base=128, random m_tready → 256 beats covering addresses 128..255 then 0..127; a single tlast.
- rd_reset asserted during beat 3 of length=8 → next cycle m_tvalid=0, busy=0, ram_re=0, no done. A fresh start afterwards produces a correct, complete window.
